// File: rtl/chacha_stream_xor_pkg.sv
// Constants, state encoding and the ChaCha20 core function shared by the
// stream wrapper and chacha_block.
package chacha_stream_xor_pkg;

   localparam int CHACHA_WORDS = 16;

   localparam logic [31:0] SIGMA0 = 32'h61707865;
   localparam logic [31:0] SIGMA1 = 32'h3320646e;
   localparam logic [31:0] SIGMA2 = 32'h79622d32;
   localparam logic [31:0] SIGMA3 = 32'h6b206574;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_WAIT   = 2'd2,
      S_STREAM = 2'd3
   } state_e;

   // Word i of a 512-bit state lives at [511-32i -: 32]; no byte swapping.
   function automatic logic [31:0] state_word(input logic [511:0] s, input logic [3:0] i);
      return s[{~i, 5'd0} +: 32];
   endfunction

   function automatic logic [127:0] quarter_round(input logic [31:0] a_i, input logic [31:0] b_i,
                                                  input logic [31:0] c_i, input logic [31:0] d_i);
      logic [31:0] a, b, c, d;
      a = a_i; b = b_i; c = c_i; d = d_i;
      a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
      c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
      a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
      c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
      return {a, b, c, d};
   endfunction

   // 20 rounds (10 column/diagonal pairs) followed by the feed-forward add.
   function automatic logic [511:0] chacha_core(input logic [511:0] s_in);
      logic [31:0]  x [CHACHA_WORDS];
      logic [511:0] s_out;
      for (int i = 0; i < CHACHA_WORDS; i++) x[i] = state_word(s_in, 4'(i));
      for (int r = 0; r < 10; r++) begin
         {x[0], x[4], x[8],  x[12]} = quarter_round(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = quarter_round(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = quarter_round(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = quarter_round(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = quarter_round(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = quarter_round(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = quarter_round(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = quarter_round(x[3], x[4], x[9],  x[14]);
      end
      s_out = '0;
      for (int i = 0; i < CHACHA_WORDS; i++)
         s_out = {s_out[479:0], x[i] + state_word(s_in, 4'(i))};
      return s_out;
   endfunction

endpackage

// File: rtl/chacha_block.sv
// ChaCha20 block function with a single output register (one cycle latency).
module chacha_block
   import chacha_stream_xor_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] state_in,
   output logic [511:0] state_out
);

   always_ff @(posedge clk) begin
      if (rst) state_out <= '0;
      else     state_out <= chacha_core(state_in);
   end

endmodule

// File: rtl/chacha_stream_xor_state_pack.sv
// Assembles the 512-bit ChaCha input state from constants, key, counter and nonce.
module chacha_stream_xor_state_pack
   import chacha_stream_xor_pkg::*;
(
   input  logic [255:0] key,
   input  logic [31:0]  ctr,
   input  logic [95:0]  nonce,
   output logic [511:0] state
);

   assign state = {SIGMA0, SIGMA1, SIGMA2, SIGMA3, key, ctr, nonce};

endmodule

// File: rtl/chacha_stream_xor.sv
// Keystream generation control plus a one-word-per-cycle XOR stage on a
// valid/ready stream; the counter advances every 16 words.
module chacha_stream_xor
   import chacha_stream_xor_pkg::*;
#(
   parameter int BLOCK_LAT = 1
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic [31:0]  init_ctr,
   output logic [511:0] ks_state_in,
   input  logic [511:0] ks_state_out,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_data,
   output logic         out_last,
   output logic         busy,
   output logic         ctr_wrap,
   output state_e       dbg_state
);

   localparam logic [7:0] WAIT_INIT = 8'(BLOCK_LAT - 1);

   state_e       state, state_n;
   logic [255:0] key_q;
   logic [95:0]  nonce_q;
   logic [31:0]  ctr_q;
   logic [7:0]   wait_cnt;
   logic [31:0]  ks_buf [CHACHA_WORDS];
   logic [3:0]   word_idx;
   logic [511:0] packed_state;
   logic         accept, end_of_block, ctr_max;

   chacha_stream_xor_state_pack u_pack (
      .key   (key_q),
      .ctr   (ctr_q),
      .nonce (nonce_q),
      .state (packed_state)
   );

   // Handshake: a word moves when valid & ready are both high at a rising edge;
   // valid never waits on ready, and a held valid keeps its data stable.
   // in_ready depends only on state, start and the output register, so there is
   // no combinational path from in_valid/in_data to the output side.
   assign in_ready     = (state == S_STREAM) && !start && (!out_valid || out_ready);
   assign accept       = in_valid && in_ready;
   assign end_of_block = (word_idx == 4'(CHACHA_WORDS - 1));
   assign ctr_max      = (ctr_q == 32'hFFFF_FFFF);
   assign ks_state_in  = (state == S_LOAD || state == S_WAIT) ? packed_state : '0;
   assign busy         = (state != S_IDLE);
   assign dbg_state    = state;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (start) begin
         state_n = S_LOAD;
      end else begin
         case (state)
            S_IDLE:   state_n = S_IDLE;
            S_LOAD:   state_n = S_WAIT;
            S_WAIT:   if (wait_cnt == '0) state_n = S_STREAM;
            S_STREAM: begin
               if (accept) begin
                  if (in_last)           state_n = S_IDLE;
                  else if (end_of_block) state_n = ctr_max ? S_IDLE : S_LOAD;
               end
            end
            default:  state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q     <= '0;
         nonce_q   <= '0;
         ctr_q     <= '0;
         wait_cnt  <= '0;
         word_idx  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         ctr_wrap  <= 1'b0;
         for (int i = 0; i < CHACHA_WORDS; i++) ks_buf[i] <= '0;
      end else begin
         if (start) begin
            key_q    <= key;
            nonce_q  <= nonce;
            ctr_q    <= init_ctr;
            ctr_wrap <= 1'b0;
         end
         if (state == S_LOAD) wait_cnt <= WAIT_INIT;
         if (state == S_WAIT) begin
            if (wait_cnt == '0) begin
               for (int i = 0; i < CHACHA_WORDS; i++) ks_buf[i] <= state_word(ks_state_out, 4'(i));
               word_idx <= '0;
            end else begin
               wait_cnt <= wait_cnt - 8'd1;
            end
         end
         // The output register drains regardless of state, so a pending word survives start.
         if (accept) begin
            out_data  <= in_data ^ ks_buf[word_idx];
            out_last  <= in_last;
            out_valid <= 1'b1;
            word_idx  <= word_idx + 4'd1;
            if (!in_last && end_of_block) begin
               if (ctr_max) ctr_wrap <= 1'b1;
               else         ctr_q    <= ctr_q + 32'd1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed bench for chacha_stream_xor + chacha_block against the RFC 7539 sec 2.4.2 vector.
`timescale 1ns/1ps
module tb_chacha_stream_xor;
   import chacha_stream_xor_pkg::*;

   localparam int BLOCK_LAT = 1;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst, start;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  init_ctr;
   logic [511:0] ks_state_in, ks_state_out;
   logic         in_valid, in_ready, in_last;
   logic [31:0]  in_data;
   logic         out_valid, out_ready, out_last;
   logic [31:0]  out_data;
   logic         busy, ctr_wrap;
   state_e       dbg_state;

   always #5 clk = ~clk;

   chacha_stream_xor #(.BLOCK_LAT(BLOCK_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce), .init_ctr(init_ctr),
      .ks_state_in(ks_state_in), .ks_state_out(ks_state_out),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .ctr_wrap(ctr_wrap), .dbg_state(dbg_state)
   );

   chacha_block u_blk (.clk(clk), .rst(rst), .state_in(ks_state_in), .state_out(ks_state_out));

   // ---------------- reference vectors ----------------
   localparam logic [255:0] RFC_KEY = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                       32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
   localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h00000000};
   string        msg = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
   logic [911:0] ct_all;
   logic [7:0]   pt_b [116];
   logic [7:0]   ct_b [116];
   logic [31:0]  pt_w [29];
   logic [31:0]  ct_w [29];
   logic [31:0]  ks_ref [28];

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   logic [31:0] msk_q[$];
   logic        exp_last_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] mon_e, mon_m;
   logic        mon_l;
   bit          bp_done;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++; $error("FAIL out_extra observed=%h expected=none", out_data);
         end
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_m = msk_q.pop_front();
            mon_l = exp_last_q.pop_front();
            checks++;
            assert ((out_data & mon_m) === (mon_e & mon_m)) else begin
               errors++; $error("FAIL out_data observed=%h expected=%h mask=%h", out_data, mon_e, mon_m);
            end
            checks++;
            assert (out_last === mon_l) else begin
               errors++; $error("FAIL out_last observed=%b expected=%b", out_last, mon_l);
            end
         end
      end
      if (!rst && out_valid && !out_ready) begin
         checks++;
         assert (in_ready === 1'b0) else begin
            errors++; $error("FAIL stall_ready observed=%b expected=0", in_ready);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
      key = k; nonce = n; init_ctr = c; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic lst, input logic [31:0] e,
                            input logic [31:0] m, input bit track, output int stalls);
      int cyc;
      bit ok;
      cyc = 0; ok = 0; stalls = 0;
      in_valid = 1'b1; in_data = d; in_last = lst;
      while (!ok && cyc < 64) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            if (track) begin
               exp_q.push_back(e); msk_q.push_back(m); exp_last_q.push_back(lst);
            end
         end else begin
            stalls++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("send_accept", 64'(ok), 64'd1);
   endtask

   // Random data word i of an RFC-keyed stream starting at counter 1.
   task automatic send_ks(input int i, input logic lst, output int stalls);
      logic [31:0] d;
      d = $urandom();
      send_word(d, lst, d ^ ks_ref[i], 32'hFFFF_FFFF, 1, stalls);
   endtask

   task automatic drain(input string tag);
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 100) begin
         tick();
         cyc++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ks_state_in"}, 64'(|ks_state_in), 64'd0);
      check({tag, "_out_data"},    64'(out_data),     64'd0);
      check({tag, "_in_ready"},    64'(in_ready),     64'd0);
      check({tag, "_out_valid"},   64'(out_valid),    64'd0);
      check({tag, "_out_last"},    64'(out_last),     64'd0);
      check({tag, "_busy"},        64'(busy),         64'd0);
      check({tag, "_ctr_wrap"},    64'(ctr_wrap),     64'd0);
      check({tag, "_state"},       64'(dbg_state),    64'(S_IDLE));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int st;
      logic [31:0] d;
      int ready_seen;

      ct_all = {128'h6e2e359a2568f98041ba0728dd0d6981, 128'he97e7aec1d4360c20a27afccfd9fae0b,
                128'hf91b65c5524733ab8f593dabcd62b357, 128'h1639d624e65152ab8f530c359f0861d8,
                128'h07ca0dbf500d6a6156a38e088a22b65e, 128'h52bc514d16ccf806818ce91ab7793736,
                128'h5af90bbf74a35be6b40b8eedf2785e42, 16'h874d};
      for (int i = 0; i < 116; i++) begin
         pt_b[i] = (i < 114) ? msg[i] : 8'h00;
         ct_b[i] = (i < 114) ? ct_all[911 - 8*i -: 8] : 8'h00;
      end
      for (int w = 0; w < 29; w++) begin
         pt_w[w] = {pt_b[4*w+3], pt_b[4*w+2], pt_b[4*w+1], pt_b[4*w]};
         ct_w[w] = {ct_b[4*w+3], ct_b[4*w+2], ct_b[4*w+1], ct_b[4*w]};
      end
      for (int w = 0; w < 28; w++) ks_ref[w] = ct_w[w] ^ pt_w[w];

      rst = 1'b1; start = 1'b0; key = '0; nonce = '0; init_ctr = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      tick();

      // Test 1: RFC 7539 sec 2.4.2, 114 bytes
      do_start(RFC_KEY, RFC_NONCE, 32'd1);
      @(negedge clk);
      check("t1_state_load", 64'(dbg_state), 64'(S_LOAD));
      check("t1_sigma0", 64'(ks_state_in[511:480]), 64'h61707865);
      check("t1_key0",   64'(ks_state_in[383:352]), 64'h03020100);
      check("t1_ctr",    64'(ks_state_in[127:96]),  64'd1);
      check("t1_nonce1", 64'(ks_state_in[63:32]),   64'h4a000000);
      tick();
      for (int w = 0; w < 29; w++)
         send_word(pt_w[w], w == 28, ct_w[w], (w == 28) ? 32'h0000_FFFF : 32'hFFFF_FFFF, 1, st);
      @(negedge clk);
      check("t1_busy_after_last", 64'(busy), 64'd0);
      drain("t1_drain");

      // Test 2: random backpressure across 40 words (28 + restart + 12)
      bp_done = 0;
      fork
         begin
            do_start(RFC_KEY, RFC_NONCE, 32'd1);
            for (int w = 0; w < 28; w++) send_word(pt_w[w], w == 27, ct_w[w], 32'hFFFF_FFFF, 1, st);
            do_start(RFC_KEY, RFC_NONCE, 32'd1);
            for (int w = 0; w < 12; w++) send_word(pt_w[w], w == 11, ct_w[w], 32'hFFFF_FFFF, 1, st);
            bp_done = 1;
         end
         begin
            while (!bp_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain("t2_drain");

      // Test 3: block boundary with in_valid held high
      do_start(RFC_KEY, RFC_NONCE, 32'd1);
      for (int w = 0; w < 16; w++) send_ks(w, 1'b0, st);
      d = $urandom();
      in_valid = 1'b1; in_data = d; in_last = 1'b1;
      @(negedge clk);
      check("t3_ready_load", 64'(in_ready), 64'd0);
      check("t3_state_load", 64'(dbg_state), 64'(S_LOAD));
      check("t3_next_ctr", 64'(ks_state_in[127:96]), 64'd2);
      tick();
      send_word(d, 1'b1, d ^ ks_ref[16], 32'hFFFF_FFFF, 1, st);
      check("t3_bubble", 64'(1 + st), 64'(1 + BLOCK_LAT));
      drain("t3_drain");

      // Test 4: counter wrap
      do_start({8{32'hdeadbeef}}, 96'h0123456789abcdef01234567, 32'hFFFF_FFFF);
      @(negedge clk);
      check("t4_ctr_max", 64'(ks_state_in[127:96]), 64'hFFFF_FFFF);
      tick();
      for (int w = 0; w < 16; w++) send_word($urandom(), 1'b0, 32'd0, 32'd0, 1, st);
      @(negedge clk);
      check("t4_ctr_wrap", 64'(ctr_wrap), 64'd1);
      check("t4_busy", 64'(busy), 64'd0);
      check("t4_in_ready", 64'(in_ready), 64'd0);
      tick();
      in_valid = 1'b1; in_data = $urandom();
      ready_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (in_ready) ready_seen++;
         tick();
      end
      in_valid = 1'b0;
      check("t4_word16_blocked", 64'(ready_seen), 64'd0);
      drain("t4_drain");
      do_start(RFC_KEY, RFC_NONCE, 32'd1);
      @(negedge clk);
      check("t4_wrap_cleared", 64'(ctr_wrap), 64'd0);
      check("t4_busy_restart", 64'(busy), 64'd1);
      tick();

      // Test 5: in_last at word 5, then restart reproduces the keystream
      for (int w = 0; w < 6; w++) send_ks(w, w == 5, st);
      @(negedge clk);
      check("t5_busy_fall", 64'(busy), 64'd0);
      tick();
      drain("t5_drain_a");
      do_start(RFC_KEY, RFC_NONCE, 32'd1);
      for (int w = 0; w < 16; w++) send_ks(w, w == 15, st);
      drain("t5_drain_b");

      // Test 6: reset with an in-flight word, then start during WAIT
      do_start(RFC_KEY, RFC_NONCE, 32'd1);
      for (int w = 0; w < 7; w++) send_ks(w, 1'b0, st);
      drain("t6_drain_pre");
      tick();
      out_ready = 1'b0;
      send_word($urandom(), 1'b0, 32'd0, 32'd0, 0, st);
      @(negedge clk);
      check("t6_inflight", 64'(out_valid), 64'd1);
      rst = 1'b1; in_valid = 1'b1; in_data = $urandom();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check_reset_values("t6_reset");
      out_ready = 1'b1;
      tick();
      do_start({8{32'h5a5a5a5a}}, 96'hfeedfacecafebeef00000001, 32'd5);
      tick();
      @(negedge clk);
      check("t6_in_wait", 64'(dbg_state), 64'(S_WAIT));
      do_start(RFC_KEY, RFC_NONCE, 32'd1);
      @(negedge clk);
      check("t6_relatch_load", 64'(dbg_state), 64'(S_LOAD));
      check("t6_relatch_ctr", 64'(ks_state_in[127:96]), 64'd1);
      tick();
      for (int w = 0; w < 18; w++) send_ks(w, w == 17, st);
      drain("t6_drain_post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
